router_input_ctrl: RTL

- Upstream neighbour of router_output_ctrl on the NoC ring. Accepts 64-bit packets from an incoming ring link and buffers them in two virtual-channel slots, even and odd.
- Decodes the hop field of each buffered packet. A packet with hop 0 requests the local-port output ctrl. Any other packet requests the forward (next ring hop) output ctrl, with its hop field decremented.
- Uses the same global polarity bit as router_output_ctrl. Link-side writes and router-side reads always target opposite buffers, so they never conflict.

---
 rtl/router_input_ctrl.sv | 57 +++++
 1 files changed

// File: rtl/router_input_ctrl.sv
// router_input_ctrl: two-slot even/odd ring input buffer with hop decode toward local/forward output ctrls
module router_input_ctrl #(
   parameter int DATA_W  = 64,
   parameter int HOP_LSB = 48,
   parameter int HOP_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              polarity,
   input  logic              si,
   output logic              ri,
   input  logic [DATA_W-1:0] di,
   output logic              req_fwd,
   input  logic              ack_fwd,
   output logic              req_loc,
   input  logic              ack_loc,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] even_buf_q, even_buf_d, odd_buf_q, odd_buf_d;
   logic              even_full_q, even_full_d, odd_full_q, odd_full_d;
   logic [DATA_W-1:0] r_buf, fwd_buf;
   logic [HOP_W-1:0]  hop;
   logic              w_full, r_full, is_loc, wr, drain;
   always_comb begin
      w_full  = polarity ? odd_full_q : even_full_q;
      r_full  = polarity ? even_full_q : odd_full_q;
      r_buf   = polarity ? even_buf_q : odd_buf_q;
      hop     = r_buf[HOP_LSB +: HOP_W];
      is_loc  = hop == '0;
      fwd_buf = r_buf;
      fwd_buf[HOP_LSB +: HOP_W] = hop - HOP_W'(1);
      ri      = ~reset & ~w_full;
      req_loc = ~reset & r_full & is_loc;
      req_fwd = ~reset & r_full & ~is_loc;
      dout    = (reset | ~r_full) ? '0 : (is_loc ? r_buf : fwd_buf);
      wr      = si & ri;
      drain   = (req_fwd & ack_fwd) | (req_loc & ack_loc);
      // write and drain always hit opposite buffers, so at most one applies per slot
      even_buf_d  = (wr & ~polarity) ? di : even_buf_q;
      odd_buf_d   = (wr & polarity) ? di : odd_buf_q;
      even_full_d = (wr & ~polarity) | (even_full_q & ~(drain & polarity));
      odd_full_d  = (wr & polarity) | (odd_full_q & ~(drain & ~polarity));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         even_buf_q  <= '0;
         odd_buf_q   <= '0;
         even_full_q <= 1'b0;
         odd_full_q  <= 1'b0;
      end else begin
         even_buf_q  <= even_buf_d;
         odd_buf_q   <= odd_buf_d;
         even_full_q <= even_full_d;
         odd_full_q  <= odd_full_d;
      end
   end
endmodule
